// File: rtl/ram64m_fifo_ctrl.sv
// 64-entry FWFT FIFO controller sequencing an external bank of RAM64M cells (WIDTH/4 cells).
// Optional sticky overflow/underflow flags are enabled by defining RAM64M_FIFO_ERR_EN.
module ram64m_fifo_ctrl #(
   parameter int unsigned WIDTH            = 4,
   parameter int unsigned ALMOST_FULL_THR  = 48,
   parameter int unsigned ALMOST_EMPTY_THR = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             FLUSH,
   input  logic             WR_VALID,
   output logic             WR_READY,
   input  logic [WIDTH-1:0] WR_DATA,
   output logic             RD_VALID,
   input  logic             RD_READY,
   output logic [WIDTH-1:0] RD_DATA,
   output logic             MEM_WE,
   output logic [5:0]       MEM_WADDR,
   output logic [WIDTH-1:0] MEM_DI,
   output logic [5:0]       MEM_RADDR,
   input  logic [WIDTH-1:0] MEM_DO,
   output logic [6:0]       LEVEL,
   output logic             ALMOST_FULL,
   output logic             ALMOST_EMPTY,
   output logic             ERR_OVF,
   output logic             ERR_UDF
);

   localparam logic [6:0] AfThr = 7'(ALMOST_FULL_THR);
   localparam logic [6:0] AeThr = 7'(ALMOST_EMPTY_THR);

   logic [6:0] wr_ptr_q, wr_ptr_d;
   logic [6:0] rd_ptr_q, rd_ptr_d;
   logic [6:0] level_q, level_d;
   logic       init_q;
   logic       wr_ready_q, wr_ready_d;
   logic       afull_q, afull_d;
   logic       aempty_q, aempty_d;
   logic       empty, full, full_d;
   logic       push, pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[5:0] == rd_ptr_q[5:0]) && (wr_ptr_q[6] != rd_ptr_q[6]);
   assign push  = WR_VALID && wr_ready_q && init_q && !FLUSH;
   assign pop   = RD_READY && !empty && !FLUSH;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 7'd1;
         if (pop)  rd_ptr_d = rd_ptr_q + 7'd1;
      end
      // Status is derived from next-state pointers so it stays coherent with RD_VALID.
      full_d     = (wr_ptr_d[5:0] == rd_ptr_d[5:0]) && (wr_ptr_d[6] != rd_ptr_d[6]);
      wr_ready_d = !full_d;
      level_d    = wr_ptr_d - rd_ptr_d;
      afull_d    = (level_d >= AfThr);
      aempty_d   = (level_d <= AeThr);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         init_q     <= 1'b0;
         wr_ready_q <= 1'b0;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         init_q     <= 1'b1;
         wr_ready_q <= wr_ready_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
      end
   end

`ifdef RAM64M_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q || (WR_VALID && full && init_q);
      udf_d = udf_q || (RD_READY && empty);
      if (FLUSH) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ERR_OVF = ovf_q;
   assign ERR_UDF = udf_q;
`else
   assign ERR_OVF = 1'b0;
   assign ERR_UDF = 1'b0;
`endif

   assign WR_READY     = wr_ready_q;
   assign RD_VALID     = !empty;
   assign RD_DATA      = MEM_DO;
   assign MEM_WE       = push && RST_N;
   assign MEM_WADDR    = wr_ptr_q[5:0];
   assign MEM_DI       = WR_DATA;
   assign MEM_RADDR    = rd_ptr_q[5:0];
   assign LEVEL        = level_q;
   assign ALMOST_FULL  = afull_q;
   assign ALMOST_EMPTY = aempty_q;

endmodule

// File: tb/tb_ram64m_fifo_ctrl.sv
// Directed bench for ram64m_fifo_ctrl with a behavioural RAM64M bank stand-in.
module tb_ram64m_fifo_ctrl;

   localparam int unsigned W = 4;
`ifdef RAM64M_FIFO_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         FLUSH = 1'b0;
   logic         WR_VALID = 1'b0;
   logic         WR_READY;
   logic [W-1:0] WR_DATA = '0;
   logic         RD_VALID;
   logic         RD_READY = 1'b0;
   logic [W-1:0] RD_DATA;
   logic         MEM_WE;
   logic [5:0]   MEM_WADDR;
   logic [W-1:0] MEM_DI;
   logic [5:0]   MEM_RADDR;
   logic [W-1:0] MEM_DO;
   logic [6:0]   LEVEL;
   logic         ALMOST_FULL;
   logic         ALMOST_EMPTY;
   logic         ERR_OVF;
   logic         ERR_UDF;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] mem [64];
   logic [W-1:0] exp_q [$];
   logic [5:0]   wa;
   logic [W-1:0] d;

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (MEM_WE) mem[MEM_WADDR] <= MEM_DI;
   assign MEM_DO = mem[MEM_RADDR];

   ram64m_fifo_ctrl #(
      .WIDTH(W),
      .ALMOST_FULL_THR(48),
      .ALMOST_EMPTY_THR(8)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
      .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
      .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_DI(MEM_DI),
      .MEM_RADDR(MEM_RADDR), .MEM_DO(MEM_DO),
      .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
      .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset held for 3 cycles; MEM_WE must stay low even with WR_VALID asserted.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      WR_VALID = 1'b1;
      #1;
      check("rst_mem_we", MEM_WE, 0);
      check("rst_wr_ready", WR_READY, 0);
      check("rst_rd_valid", RD_VALID, 0);
      check("rst_level", LEVEL, 0);
      check("rst_aempty", ALMOST_EMPTY, 1);
      check("rst_afull", ALMOST_FULL, 0);
      check("rst_err_ovf", ERR_OVF, 0);
      check("rst_err_udf", ERR_UDF, 0);
      WR_VALID = 1'b0;
      RST_N = 1'b1;
      #1;
      check("init_wr_ready_lo", WR_READY, 0);
      @(negedge CLK);
      check("init_wr_ready_hi", WR_READY, 1);
      check("init_level", LEVEL, 0);

      // Fill 64 words
      for (int i = 0; i < 64; i++) begin
         if (i == 8)  check("aempty_at_8", ALMOST_EMPTY, 1);
         if (i == 9)  check("aempty_at_9", ALMOST_EMPTY, 0);
         if (i == 47) check("afull_at_47", ALMOST_FULL, 0);
         if (i == 48) check("afull_at_48", ALMOST_FULL, 1);
         WR_VALID = 1'b1;
         WR_DATA  = 4'(i);
         #1;
         check("fill_we", MEM_WE, 1);
         check("fill_waddr", MEM_WADDR, i);
         check("fill_di", MEM_DI, i % 16);
         @(negedge CLK);
      end
      #1;
      check("full_wr_ready", WR_READY, 0);
      check("full_level", LEVEL, 64);
      check("full_afull", ALMOST_FULL, 1);
      check("full_rd_valid", RD_VALID, 1);
      check("ovf_we", MEM_WE, 0);
      @(negedge CLK);
      check("ovf_err", ERR_OVF, ErrEn);
      check("ovf_level", LEVEL, 64);
      WR_VALID = 1'b0;

      // Drain and order
      for (int i = 0; i < 64; i++) begin
         RD_READY = 1'b1;
         #1;
         check("drain_valid", RD_VALID, 1);
         check("drain_raddr", MEM_RADDR, i);
         check("drain_data", RD_DATA, i % 16);
         @(negedge CLK);
      end
      RD_READY = 1'b0;
      #1;
      check("drained_valid", RD_VALID, 0);
      check("drained_level", LEVEL, 0);
      check("drained_wr_ready", WR_READY, 1);
      check("drained_udf", ERR_UDF, 0);
      RD_READY = 1'b1;
      @(negedge CLK);
      RD_READY = 1'b0;
      @(negedge CLK);
      check("udf_err", ERR_UDF, ErrEn);
      check("udf_level", LEVEL, 0);
      check("udf_rd_valid", RD_VALID, 0);

      // Streaming across the 63->0 wrap at a steady level of 5
      wa = 6'd0;
      for (int k = 0; k < 5; k++) begin
         WR_VALID = 1'b1;
         WR_DATA  = 4'(k + 10);
         exp_q.push_back(WR_DATA);
         wa++;
         @(negedge CLK);
      end
      RD_READY = 1'b1;
      for (int i = 0; i < 200; i++) begin
         d = 4'((i * 7 + 3) % 16);
         WR_DATA = d;
         #1;
         check("stream_level", LEVEL, 5);
         check("stream_waddr", MEM_WADDR, wa);
         check("stream_data", RD_DATA, exp_q[0]);
         void'(exp_q.pop_front());
         exp_q.push_back(d);
         wa++;
         @(negedge CLK);
      end
      RD_READY = 1'b0;
      for (int k = 0; k < 15; k++) begin
         WR_DATA = 4'(k);
         @(negedge CLK);
      end
      check("pre_flush_level", LEVEL, 20);

      // Flush with push and pop requested in the same cycle
      FLUSH    = 1'b1;
      WR_VALID = 1'b1;
      RD_READY = 1'b1;
      #1;
      check("flush_we", MEM_WE, 0);
      @(negedge CLK);
      FLUSH    = 1'b0;
      WR_VALID = 1'b0;
      RD_READY = 1'b0;
      #1;
      check("flush_level", LEVEL, 0);
      check("flush_rd_valid", RD_VALID, 0);
      check("flush_aempty", ALMOST_EMPTY, 1);
      check("flush_wr_ready", WR_READY, 1);
      check("flush_ovf", ERR_OVF, 0);
      check("flush_udf", ERR_UDF, 0);
      WR_VALID = 1'b1;
      WR_DATA  = 4'd9;
      #1;
      check("post_flush_we", MEM_WE, 1);
      check("post_flush_waddr", MEM_WADDR, 0);
      check("no_bypass_valid", RD_VALID, 0);
      @(negedge CLK);
      WR_VALID = 1'b0;
      #1;
      check("post_flush_valid", RD_VALID, 1);
      check("post_flush_data", RD_DATA, 9);
      check("post_flush_raddr", MEM_RADDR, 0);
      check("post_flush_level", LEVEL, 1);

      // Mid-operation asynchronous reset
      RST_N = 1'b0;
      #1;
      check("midrst_level", LEVEL, 0);
      check("midrst_rd_valid", RD_VALID, 0);
      check("midrst_wr_ready", WR_READY, 0);
      check("midrst_aempty", ALMOST_EMPTY, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram64m_fifo_ctrl.md
Name: ram64m_fifo_ctrl

Overview:
- Synchronous 64-entry FIFO controller that sequences a bank of RAM64M distributed-RAM cells.
- Uses WIDTH/4 cells, each holding 4 bits.
- Owns the write and read pointers, the write enable and the status flags. Producer and consumer each see a valid/ready handshake.
- Storage stays external: the block drives one shared write address and write enable, and a read address. Read data returns asynchronously from the RAM and passes to the consumer first-word-fall-through.

Parameters:
- WIDTH, 4, data width; must be a multiple of 4 (one RAM64M cell per 4 bits).
- ALMOST_FULL_THR, 48, ALMOST_FULL asserts when level >= this value (1..64).
- ALMOST_EMPTY_THR, 8, ALMOST_EMPTY asserts when level <= this value (0..63).

Ports:
- CLK  in  1  single clock; also drives the RAM WCLK.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of all FIFO contents.
- WR_VALID  in  1  producer has data.
- WR_READY  out  1  FIFO accepts data.
- WR_DATA  in  WIDTH  producer data.
- RD_VALID  out  1  head entry available.
- RD_READY  in  1  consumer takes the head entry.
- RD_DATA  out  WIDTH  head entry (equals MEM_DO).
- MEM_WE  out  1  RAM write enable.
- MEM_WADDR  out  6  RAM write address.
- MEM_DI  out  WIDTH  RAM write data (equals WR_DATA).
- MEM_RADDR  out  6  RAM read address.
- MEM_DO  in  WIDTH  RAM asynchronous read data.
- LEVEL  out  7  current occupancy, 0..64.
- ALMOST_FULL  out  1  level >= ALMOST_FULL_THR.
- ALMOST_EMPTY  out  1  level <= ALMOST_EMPTY_THR.
- ERR_OVF  out  1  sticky overflow flag (see Optional Feature).
- ERR_UDF  out  1  sticky underflow flag (see Optional Feature).

Behaviour:
- State: 7-bit wr_ptr and rd_ptr. Bit 6 is the wrap bit; bits 5:0 address the RAM. A registered init flag tracks reset release.
- Reset (RST_N low, asynchronous):
  - wr_ptr = rd_ptr = 0, LEVEL = 0.
  - WR_READY = 0, RD_VALID = 0, ALMOST_FULL = 0, ALMOST_EMPTY = 1, ERR_OVF = ERR_UDF = 0.
  - MEM_WE = 0 combinationally while RST_N is low.
- Reset release: WR_READY rises on the first CLK edge after RST_N deasserts (init cycle), then follows the full flag.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[5:0] == rd_ptr[5:0]) and wrap bits differ.
  - WR_READY = init and !full; registered, so it does not see a same-cycle pop.
  - RD_VALID = !empty.
- Push = WR_VALID and WR_READY:
  - MEM_WE = push, combinational; MEM_WADDR = wr_ptr[5:0]; MEM_DI = WR_DATA.
  - wr_ptr increments modulo 128 at the CLK edge.
- Pop = RD_VALID and RD_READY: rd_ptr increments modulo 128. MEM_RADDR = rd_ptr[5:0] combinationally, and RD_DATA = MEM_DO.
- Latency:
  - A word pushed at edge N is visible on RD_VALID/RD_DATA after edge N (1-cycle write-to-read).
  - Write into an empty FIFO: no same-cycle bypass.
- LEVEL = wr_ptr - rd_ptr (7-bit, modulo 128).
  - LEVEL, ALMOST_FULL and ALMOST_EMPTY are registered.
  - They are updated every edge from next-state pointers, so they are coherent with RD_VALID/WR_READY.
- Simultaneous push and pop: both pointers advance and LEVEL is unchanged. When full, WR_READY = 0 blocks the push even if a pop occurs that cycle.
- Wrap-around: address 63 -> 0 with the wrap bit toggling. Must be seamless for continuous streaming.
- FLUSH:
  - On the clock edge with FLUSH = 1, both pointers become 0 and LEVEL becomes 0.
  - MEM_WE is forced to 0 in that cycle; push and pop that cycle are discarded.
  - The ERR flags are also cleared.
- Mid-operation reset: everything returns immediately to reset values; RAM contents are undefined to the user.

Optional Feature:
- Macro: RAM64M_FIFO_ERR_EN.
- Defined:
  - ERR_OVF sets (sticky) when WR_VALID = 1 while full and init = 1.
  - ERR_UDF sets (sticky) when RD_READY = 1 while empty.
  - Both clear on reset or FLUSH.
- Undefined: ERR_OVF and ERR_UDF are tied to 0 and no logic is generated.

Test Plan:
- Reset/init: hold RST_N = 0 for 3 cycles, release -> WR_READY = 0 for 1 edge then 1; RD_VALID = 0, LEVEL = 0, ALMOST_EMPTY = 1.
- Fill: push 64 words 0..63 (WIDTH = 4, values mod 16), no pops ->
  - MEM_WADDR 0..63 with MEM_WE each cycle;
  - after the 64th push: WR_READY = 0, LEVEL = 64, ALMOST_FULL = 1;
  - a 65th WR_VALID produces no MEM_WE.
- Drain and order: pop all 64 -> RD_DATA sequence matches the pushes, MEM_RADDR 0..63, RD_VALID = 0 after the last pop, LEVEL = 0.
- Streaming wrap: 200 cycles with push and pop every cycle, starting at LEVEL = 5 -> LEVEL stays 5, pointers wrap past 63 -> 0, data order is preserved.
- Flush: at LEVEL = 20, assert FLUSH with WR_VALID = 1 -> MEM_WE = 0 that cycle; next cycle LEVEL = 0, RD_VALID = 0, and a subsequent push lands at MEM_WADDR = 0.
- Errors (RAM64M_FIFO_ERR_EN defined): RD_READY = 1 when empty -> ERR_UDF = 1 sticky; WR_VALID = 1 when full -> ERR_OVF = 1; FLUSH clears both. With the macro undefined, both stay 0.
